version_string_streamer: RTL and testbench
==========================================

# version_string_streamer

Bus-master sequencer that reads the packed build version string out of the version string register block and streams it, one ASCII byte at a time, to a byte sink (the UART TX holding stage) over a valid/ready handshake. It sits beside the CPU on the shared peripheral bus and requests the bus through the bus arbiter once per word. Its purpose is to print the firmware/gateware version at power-up or on a debug-console command without CPU involvement.

## Interface
- BaseAddress, 0: bus address of word 0 of the version string block
- NumWords, 22: number of data_width words holding the string
- ReadLatency, 1: cycles after the address is first driven until bus_data_i is valid (0..3)
- AppendCrLf, 1: 1 = emit 0x0D, 0x0A after the string
- address_width, 15: bus address width
- data_width, 16: bus data width; a multiple of 8

Ports:
- clk_i  in  1  system clock; single clock domain
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle start pulse
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse when the last byte is accepted
- bus_req_o  out  1  bus request to the arbiter
- bus_gnt_i  in  1  bus grant
- bus_addr_o  out  address_width  read address
- bus_rd_wr_o  out  1  0 = read; held 1 otherwise (the block never writes)
- bus_data_i  in  data_width  read data
- tx_data_o  out  8  byte to sink
- tx_valid_o  out  1  byte valid
- tx_ready_i  in  1  sink ready

## Operation
- States: IDLE, REQ, RD, EMIT, CR, LF, DONE.
- IDLE: when start_i=1, load word index = NumWords-1 and go to REQ. start_i in any other state is ignored.
- REQ: bus_req_o=1. When bus_gnt_i=1, go to RD.
- RD:
  - bus_addr_o = BaseAddress + word index and bus_rd_wr_o = 0, held for ReadLatency+1 cycles.
  - bus_data_i is captured into the shift register on the last of these cycles.
  - bus_req_o stays high throughout.
  - If bus_gnt_i drops during RD, abandon the access and return to REQ; no data is captured.
- EMIT:
  - bus_req_o=0 and bus_rd_wr_o=1.
  - Bytes are emitted MSB byte first (data_width/8 per word). Words are read from the highest index down to 0, so the string comes out in reading order.
  - Byte 0x00 is skipped: it costs one cycle with tx_valid_o low. It covers the leading NUL padding of short strings.
  - After the last byte of a word: if word index > 0, decrement it and go to REQ. If word index = 0, go to CR when AppendCrLf=1, else to DONE.
- CR / LF: emit 0x0D then 0x0A with the same handshake.
- DONE: done_o=1 for one cycle, busy_o drops, go to IDLE.
- Handshake:
  - A byte transfers on any cycle with tx_valid_o & tx_ready_i.
  - Once tx_valid_o is high, tx_data_o is stable and tx_valid_o stays high until transfer.
  - The next byte may be valid in the cycle after the transfer, so back-to-back bytes are allowed.
- Reset at any time returns to IDLE with every output at its reset value. A subsequent start begins again at word NumWords-1.
- Address arithmetic is done at address_width bits; wrap-around is not supported. BaseAddress+NumWords-1 must fit in address_width.

## Timing
- Reset values: busy_o=0, done_o=0, bus_req_o=0, bus_addr_o=0, bus_rd_wr_o=1, tx_data_o=0, tx_valid_o=0.
- All outputs are registered.
- Start at cycle 0 → busy_o=1 and bus_req_o=1 at cycle 1.
- Grant sampled high at cycle g → address and rd_wr=0 driven at cycles g+1 .. g+1+ReadLatency; data captured at the end of cycle g+1+ReadLatency.
- First tx_valid_o of a word at cycle g+2+ReadLatency.
- Per word with a grant already high and the sink always ready: 1 (REQ) + ReadLatency+1 (RD) + data_width/8 (EMIT) cycles.
- Full transfer with the sink always ready and no NULs: done_o occurs one cycle after LF is accepted.
- Simultaneous start_i and reset_i: reset wins.

## Test plan
- **Reset:** assert reset_i mid-EMIT → next cycle all outputs at reset values. Restart → first read address is BaseAddress+NumWords-1.
- **Basic string:** NumWords=2, data_width=16, word1=0x4142, word0=0x4344, sink always ready → bytes 0x41, 0x42, 0x43, 0x44, 0x0D, 0x0A, then one done_o pulse. Reads occur at BaseAddress+1 then BaseAddress.
- **NUL padding:** word1=0x0000, word0=0x4849 → only 0x48, 0x49, 0x0D, 0x0A emitted. tx_valid_o is low for 2 cycles in word1's EMIT.
- **Backpressure:** hold tx_ready_i=0 for 5 cycles on byte 0x42 → tx_valid_o=1 and tx_data_o=0x42 stable for all 5 cycles. No byte is lost or duplicated.
- **Arbitration:**
  - bus_gnt_i held low 10 cycles → bus_req_o=1 and bus_rd_wr_o=1 throughout.
  - Dropping the grant mid-RD → re-request, and the same address is re-read.
  - start_i pulsed while busy → no effect on the byte sequence.
- **ReadLatency=3:** address held 4 cycles, and data is sampled only on the 4th cycle. A bus model that changes bus_data_i on cycles 1-3 must not corrupt the output.

Source files
------------

// File: rtl/version_string_streamer.sv
// rtl/version_string_streamer.sv - bus-master that streams the packed version string as bytes
// Words are read highest index first and emitted MSB byte first; NUL bytes are skipped.

module version_string_streamer #(
  parameter int BaseAddress   = 0,
  parameter int NumWords      = 22,
  parameter int ReadLatency   = 1,
  parameter int AppendCrLf    = 1,
  parameter int address_width = 15,
  parameter int data_width    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     bus_req_o,
  input  logic                     bus_gnt_i,
  output logic [address_width-1:0] bus_addr_o,
  output logic                     bus_rd_wr_o,
  input  logic [data_width-1:0]    bus_data_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i
);

  localparam int Bpw  = data_width / 8;
  localparam int IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int LatW = (ReadLatency > 0) ? $clog2(ReadLatency + 1) : 1;
  localparam int BcW  = (Bpw > 1) ? $clog2(Bpw) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_EMIT, S_CR, S_LF, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [LatW-1:0]          lat_q, lat_d;
  logic [BcW-1:0]           bcnt_q, bcnt_d;
  logic [data_width-1:0]    rest_q, rest_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     req_q, req_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic                     rdwr_q, rdwr_d;
  logic [7:0]               txd_q, txd_d;
  logic                     txv_q, txv_d;

  logic       byte_done;
  logic [7:0] first_byte;

  // A NUL slot (valid low) retires in one cycle just like an accepted byte.
  assign byte_done  = ~txv_q | tx_ready_i;
  assign first_byte = bus_data_i[data_width-1 -: 8];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    bcnt_d  = bcnt_q;
    rest_d  = rest_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    req_d   = req_q;
    addr_d  = addr_q;
    rdwr_d  = rdwr_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          idx_d   = IdxW'(NumWords - 1);
          busy_d  = 1'b1;
          req_d   = 1'b1;
        end
      end
      S_REQ: begin
        if (bus_gnt_i) begin
          state_d = S_RD;
          addr_d  = address_width'(BaseAddress) + address_width'(idx_q);
          rdwr_d  = 1'b0;
          lat_d   = '0;
        end
      end
      S_RD: begin
        if (!bus_gnt_i) begin
          state_d = S_REQ;
          rdwr_d  = 1'b1;
        end else if (lat_q == LatW'(ReadLatency)) begin
          state_d = S_EMIT;
          req_d   = 1'b0;
          rdwr_d  = 1'b1;
          bcnt_d  = '0;
          rest_d  = bus_data_i << 8;
          txd_d   = first_byte;
          txv_d   = (first_byte != 8'h00);
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (byte_done) begin
          if (bcnt_q != BcW'(Bpw - 1)) begin
            bcnt_d = bcnt_q + 1'b1;
            rest_d = rest_q << 8;
            txd_d  = rest_q[data_width-1 -: 8];
            txv_d  = (rest_q[data_width-1 -: 8] != 8'h00);
          end else begin
            txv_d = 1'b0;
            if (idx_q != '0) begin
              idx_d   = idx_q - 1'b1;
              state_d = S_REQ;
              req_d   = 1'b1;
            end else if (AppendCrLf != 0) begin
              state_d = S_CR;
              txd_d   = 8'h0D;
              txv_d   = 1'b1;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_CR: begin
        if (tx_ready_i) begin
          state_d = S_LF;
          txd_d   = 8'h0A;
        end
      end
      S_LF: begin
        if (tx_ready_i) begin
          state_d = S_DONE;
          txv_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lat_q   <= '0;
      bcnt_q  <= '0;
      rest_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      rdwr_q  <= 1'b1;
      txd_q   <= 8'h00;
      txv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      bcnt_q  <= bcnt_d;
      rest_q  <= rest_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rdwr_q  <= rdwr_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign bus_req_o   = req_q;
  assign bus_addr_o  = addr_q;
  assign bus_rd_wr_o = rdwr_q;
  assign tx_data_o   = txd_q;
  assign tx_valid_o  = txv_q;

endmodule

// File: tb/tb_version_string_streamer.sv
// tb/tb_version_string_streamer.sv - scoreboard bench for version_string_streamer
// Bus and sink models run on the falling edge; expected bytes/addresses are queued at start.

module tb_version_string_streamer;

  localparam int BA  = 'h100;
  localparam int NW  = 4;
  localparam int RL  = 3;
  localparam int AW  = 15;
  localparam int DW  = 16;
  localparam int BPW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic          bus_gnt_i = 1'b0;
  logic          tx_ready_i = 1'b0;
  logic [DW-1:0] bus_data_i = '0;
  logic          busy_o, done_o, bus_req_o, bus_rd_wr_o, tx_valid_o;
  logic [AW-1:0] bus_addr_o;
  logic [7:0]    tx_data_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [DW-1:0] mem [NW];
  byte unsigned  exp_bytes[$];
  int            exp_addr[$];
  int            gnt_mode = 1;
  int            rdy_mode = 1;
  bit            chk_en = 1'b0;
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            first_valid_cyc = -1;
  int            s_cyc = 0;

  version_string_streamer #(
    .BaseAddress(BA), .NumWords(NW), .ReadLatency(RL), .AppendCrLf(1),
    .address_width(AW), .data_width(DW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_addr_o(bus_addr_o),
    .bus_rd_wr_o(bus_rd_wr_o), .bus_data_i(bus_data_i), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rand_char();
    if ($urandom_range(0, 3) == 0) return 8'h00;
    return 8'($urandom_range(32, 126));
  endfunction

  task automatic fill_random();
    for (int w = 0; w < NW; w++) mem[w] = {rand_char(), rand_char()};
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_req"}, bus_req_o, 1'b0);
    chk({tag, "_addr"}, bus_addr_o, '0);
    chk({tag, "_rdwr"}, bus_rd_wr_o, 1'b1);
    chk({tag, "_txdata"}, tx_data_o, 8'h00);
    chk({tag, "_txvalid"}, tx_valid_o, 1'b0);
  endtask

  // Reference model: the string read top word down, bytes high to low, NULs dropped, CR LF appended.
  task automatic issue_start();
    @(negedge clk);
    start_i = 1'b1;
    s_cyc = cyc;
    first_valid_cyc = -1;
    for (int w = NW - 1; w >= 0; w--) begin
      exp_addr.push_back(BA + w);
      for (int b = BPW - 1; b >= 0; b--) begin
        if (mem[w][b*8 +: 8] != 8'h00) exp_bytes.push_back(mem[w][b*8 +: 8]);
      end
    end
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Bus slave, grant/ready drivers and output monitor.
  initial begin
    int hold_cnt = 0;
    bit prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit lf_prev = 1'b0;
    int ai;
    forever begin
      @(negedge clk);
      case (gnt_mode)
        0: bus_gnt_i = 1'b0;
        1: bus_gnt_i = 1'b1;
        default: bus_gnt_i = ($urandom_range(0, 3) != 0);
      endcase
      case (rdy_mode)
        0: tx_ready_i = 1'b0;
        1: tx_ready_i = 1'b1;
        default: tx_ready_i = ($urandom_range(0, 2) != 0);
      endcase
      if (!bus_rd_wr_o) hold_cnt = (prev_rd && bus_addr_o == prev_addr) ? hold_cnt + 1 : 0;
      else hold_cnt = 0;
      prev_rd = !bus_rd_wr_o;
      prev_addr = bus_addr_o;
      ai = int'(bus_addr_o) - BA;
      // Data is valid only on the final cycle of the address hold; garbage before that.
      if (!bus_rd_wr_o && hold_cnt == RL && ai >= 0 && ai < NW) bus_data_i = mem[ai];
      else bus_data_i = DW'($urandom);
      if (chk_en && !reset_i) begin
        if (!bus_rd_wr_o) begin
          if (exp_addr.size() == 0) chk("rd_addr_unexpected", 32'd1, 32'd0);
          else chk("rd_addr", bus_addr_o, exp_addr[0]);
          chk("rd_hold_within_latency", hold_cnt <= RL, 1'b1);
          chk("req_during_rd", bus_req_o, 1'b1);
          if (hold_cnt == RL && bus_gnt_i && exp_addr.size() > 0) void'(exp_addr.pop_front());
        end
        if (prev_stall) begin
          chk("stall_valid_held", tx_valid_o, 1'b1);
          chk("stall_data_stable", tx_data_o, prev_data);
        end
        if (tx_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (tx_valid_o && tx_ready_i) begin
          if (exp_bytes.size() == 0) chk("byte_unexpected", tx_data_o, 32'hFFFF);
          else chk("byte", tx_data_o, exp_bytes.pop_front());
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_after_lf", lf_prev, 1'b1);
          chk("bytes_left_at_done", exp_bytes.size(), 0);
          chk("reads_left_at_done", exp_addr.size(), 0);
        end
        lf_prev = tx_valid_o && tx_ready_i && (tx_data_o == 8'h0A);
        prev_stall = tx_valid_o && !tx_ready_i;
        prev_data = tx_data_o;
      end else begin
        prev_stall = 1'b0;
        lf_prev = 1'b0;
      end
    end
  end

  initial begin
    int d0;
    int n;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_i = 1'b0;
    chk_en = 1'b1;

    // Timing with grant high, sink ready; NULs cost one cycle each like a transfer.
    gnt_mode = 1; rdy_mode = 1;
    mem[3] = 16'h4142; mem[2] = 16'h0000; mem[1] = 16'h0043; mem[0] = 16'h4445;
    d0 = done_cnt;
    issue_start();
    chk("busy_at_cycle1", busy_o, 1'b1);
    chk("req_at_cycle1", bus_req_o, 1'b1);
    wait_done(d0, 200);
    chk("first_valid_cycle", first_valid_cyc - s_cyc, 6);
    chk("done_cycle", done_cyc - s_cyc, 7 * NW + 3);
    chk("busy_low_after_done", busy_o, 1'b0);

    // Grant withheld, then random grant/ready with a stray start while busy.
    fill_random();
    gnt_mode = 0;
    d0 = done_cnt;
    issue_start();
    for (int i = 0; i < 10; i++) begin
      chk("req_while_no_gnt", bus_req_o, 1'b1);
      chk("rdwr_while_no_gnt", bus_rd_wr_o, 1'b1);
      @(negedge clk);
    end
    gnt_mode = 2; rdy_mode = 2;
    repeat (15) @(negedge clk);
    if (busy_o && !done_o) begin
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_done(d0, 3000);

    // Directed backpressure: hold off byte 0x42 for five cycles.
    fill_random();
    mem[3] = 16'h4142;
    gnt_mode = 1; rdy_mode = 1;
    d0 = done_cnt;
    issue_start();
    n = 0;
    while (!(tx_valid_o && tx_data_o == 8'h41) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("saw_byte_41", tx_valid_o && tx_data_o == 8'h41, 1'b1);
    @(posedge clk);
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", tx_valid_o, 1'b1);
      chk("bp_data", tx_data_o, 8'h42);
    end
    @(posedge clk);
    rdy_mode = 1;
    wait_done(d0, 300);

    // Random strings under random grant and sink behaviour.
    for (int r = 0; r < 6; r++) begin
      fill_random();
      gnt_mode = 2; rdy_mode = 2;
      d0 = done_cnt;
      issue_start();
      repeat ($urandom_range(3, 40)) @(negedge clk);
      if (busy_o && !done_o) begin
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
      end
      wait_done(d0, 3000);
    end

    // Reset mid-EMIT with a coincident start; reset must win, restart from the top word.
    fill_random();
    mem[3] = 16'h5152;
    gnt_mode = 1; rdy_mode = 2;
    issue_start();
    n = 0;
    while (!tx_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_emit", tx_valid_o, 1'b1);
    chk_en = 1'b0;
    reset_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk_reset_outputs("midreset");
    exp_bytes.delete();
    exp_addr.delete();
    reset_i = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", busy_o, 1'b0);
    chk_en = 1'b1;
    rdy_mode = 1;
    d0 = done_cnt;
    issue_start();
    n = 0;
    while (bus_rd_wr_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("restart_first_addr", bus_addr_o, BA + NW - 1);
    wait_done(d0, 300);
    chk("done_pulses", done_cnt, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
